cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 and exception controller at the M stage of the pipelined MIPS core.
- Consumes the registered M-stage exception code from the previous pipeline stage and evaluates hardware interrupts against SR.
- Raises a single exception/interrupt request to the pipeline flush and PC-redirect logic.
- Holds SR, Cause, EPC and PRId, and serves mfc0, mtc0 and eret.

Parameters:
- PRID, 32'h2019_0007, value returned on reads of register 15.
- HANDLER_PC, 32'h0000_4180, exception entry vector driven on handler_pc.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; all registers clear when reset==0.
- rd_addr  in  5  mfc0 register index.
- wr_addr  in  5  mtc0 register index.
- wr_data  in  32  mtc0 data.
- we  in  1  mtc0 write enable.
- pc_m  in  32  PC of the M-stage instruction.
- bd_m  in  1  M-stage instruction sits in a branch delay slot.
- exc_code  in  5  exception code from the M-stage exception-code pipeline register.
- exc_vld  in  1  exc_code carries a real exception. Code 0 (Int) with exc_vld=1 is illegal.
- hwint  in  6  external interrupt lines, level-sensitive.
- eret  in  1  eret in M stage.
- badvaddr_in  in  32  faulting address. Used only with CP0_BADVADDR_EN.
- rd_data  out  32  mfc0 result, combinational.
- epc_out  out  32  current EPC, combinational.
- exc_req  out  1  take exception this cycle, combinational.
- handler_pc  out  32  constant HANDLER_PC.

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (14): 32 bits.
  - PRId (15): constant PRID.
- Reset (reset==0, async): SR, Cause and EPC all 0. exc_req is 0 because IE=0 and exc_vld is qualified.
- Request logic:
  - irq = |(hwint & IM) & IE & ~EXL.
  - exc = exc_vld & ~EXL.
  - exc_req = irq | exc.
  - Interrupt has priority over exc_vld in the same cycle.
- Cause.IP follows hwint every cycle, registered one cycle late. This update is independent of EXL and exc_req.
- On posedge with exc_req=1:
  - EXL <= 1.
  - Cause.ExcCode <= irq ? 5'd0 : exc_code.
  - Cause.BD <= bd_m.
  - EPC <= bd_m ? pc_m-4 : pc_m, low 2 bits forced to 00. Subtraction wraps modulo 2^32.
  - A concurrent mtc0 and a concurrent eret are both ignored.
- mtc0 (we=1, exc_req=0):
  - wr_addr 12 writes IM, EXL, IE from the matching bits of wr_data.
  - wr_addr 14 writes EPC with wr_data[31:2],2'b00.
  - All other indices are ignored; Cause is read-only to software.
- eret (exc_req=0): EXL <= 0 on the next edge.
  - eret together with mtc0 to SR: the mtc0 write applies first, then EXL is forced to 0.
- mfc0: rd_data = selected register. Unmapped indices read 32'h0. No same-cycle write bypass: a read returns the pre-edge value.
- Exceptions are masked while EXL=1. A pending interrupt fires on the first cycle after eret clears EXL, provided IE=1.
- Reset asserted mid-handler: EXL, IE and EPC return to 0 immediately, not waiting for a clock edge.

Optional Feature:
- Macro: CP0_BADVADDR_EN.
- Defined:
  - Register 8 (BadVAddr) exists, 32 bits, reset 0.
  - Loaded with badvaddr_in when exc_req=1 and the taken code is 4 (AdEL) or 5 (AdES).
  - Read-only to mtc0; readable through rd_data.
- Undefined: register 8 reads 0, badvaddr_in is ignored, and no flops are generated for it.

Test Plan:
- Reset pulse low mid-run with EXL=1 and EPC=32'h3010 -> SR, Cause and EPC read 0 while reset is low, before any clock edge; exc_req=0.
- mtc0 SR 32'h0000_0401, then hwint=6'b000001 -> exc_req=1 that cycle. After the edge: EXL=1, ExcCode=0, EPC=pc_m (e.g. 32'h3008), IP[10]=1.
- exc_vld=1, exc_code=12 (Ov), pc_m=32'h3104, bd_m=1 -> after the edge: EPC=32'h3100, BD=1, ExcCode=12; a same-cycle mtc0 EPC has no effect.
- Both exc_vld=1 (code 10) and an enabled interrupt in the same cycle -> ExcCode=0. A second exc_vld on the next cycle while EXL=1 -> exc_req=0.
- eret with hwint held asserted and IE=1 -> EXL=0 after the edge, and exc_req=1 on the following cycle.
- With CP0_BADVADDR_EN: exc_code=4, badvaddr_in=32'h0000_1003 -> register 8 reads 32'h0000_1003. Without the macro it reads 0.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 / exception controller at the M stage: SR, Cause, EPC, PRId, exception request.
// Optional BadVAddr register (index 8) is built only when CP0_BADVADDR_EN is defined.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID       = 32'h2019_0007,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_addr,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        we,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exc_code,
    input  logic        exc_vld,
    input  logic [5:0]  hwint,
    input  logic        eret,
    input  logic [31:0] badvaddr_in,
    output logic [31:0] rd_data,
    output logic [31:0] epc_out,
    output logic        exc_req,
    output logic [31:0] handler_pc
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;

    logic        irq;
    logic        exc;
    logic [4:0]  taken_code;
    logic [31:0] epc_base;

    assign irq        = (|(hwint & im_q)) & ie_q & ~exl_q;
    assign exc        = exc_vld & ~exl_q;
    assign exc_req    = irq | exc;
    assign taken_code = irq ? 5'd0 : exc_code;
    assign epc_base   = bd_m ? (pc_m - 32'd4) : pc_m;

    // An exception edge owns the register file: mtc0 and eret in that cycle are dropped.
    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        im_d   = im_q;
        exl_d  = exl_q;
        ie_d   = ie_q;
        bd_d   = bd_q;
        code_d = code_q;
        epc_d  = epc_q;
        ip_d   = hwint;
        if (exc_req) begin
            exl_d  = 1'b1;
            code_d = taken_code;
            bd_d   = bd_m;
            epc_d  = epc_base & 32'hFFFF_FFFC;
        end else begin
            if (we) begin
                case (wr_addr)
                    REG_SR: begin
                        im_d  = wr_data[15:10];
                        exl_d = wr_data[1];
                        ie_d  = wr_data[0];
                    end
                    REG_EPC: epc_d = wr_data & 32'hFFFF_FFFC;
                    default: ;
                endcase
            end
            if (eret) exl_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous so a handler aborts at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q   <= '0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            bd_q   <= 1'b0;
            ip_q   <= '0;
            code_q <= '0;
            epc_q  <= '0;
        end else begin
            im_q   <= im_d;
            exl_q  <= exl_d;
            ie_q   <= ie_d;
            bd_q   <= bd_d;
            ip_q   <= ip_d;
            code_q <= code_d;
            epc_q  <= epc_d;
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_q, badvaddr_d;

    always_comb begin
        badvaddr_d = badvaddr_q;
        if (exc_req && (taken_code == 5'd4 || taken_code == 5'd5)) badvaddr_d = badvaddr_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) badvaddr_q <= '0;
        else        badvaddr_q <= badvaddr_d;
    end
`else
    logic unused_badvaddr;
    assign unused_badvaddr = ^badvaddr_in;
`endif

    always_comb begin
        rd_data = 32'h0;
        case (rd_addr)
            REG_SR:    rd_data = {16'h0, im_q, 8'h0, exl_q, ie_q};
            REG_CAUSE: rd_data = {bd_q, 15'h0, ip_q, 3'h0, code_q, 2'b00};
            REG_EPC:   rd_data = epc_q;
            REG_PRID:  rd_data = PRID;
`ifdef CP0_BADVADDR_EN
            REG_BADVADDR: rd_data = badvaddr_q;
`endif
            default:   rd_data = 32'h0;
        endcase
    end

    assign epc_out    = epc_q;
    assign handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: vector table applied through a scoreboard queue,
// plus hand-written reset-abort and post-reset sequences.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr, wr_addr, exc_code;
    logic [31:0] wr_data, pc_m, badvaddr_in;
    logic        we, bd_m, exc_vld, eret;
    logic [5:0]  hwint;
    logic [31:0] rd_data, epc_out, handler_pc;
    logic        exc_req;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .we         (we),
        .pc_m       (pc_m),
        .bd_m       (bd_m),
        .exc_code   (exc_code),
        .exc_vld    (exc_vld),
        .hwint      (hwint),
        .eret       (eret),
        .badvaddr_in(badvaddr_in),
        .rd_data    (rd_data),
        .epc_out    (epc_out),
        .exc_req    (exc_req),
        .handler_pc (handler_pc)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        bd;
        logic        ev;
        logic [4:0]  ec;
        logic [5:0]  hw;
        logic        er;
        logic [31:0] bva;
        logic        exp_req;
        logic [31:0] exp_rd;
        logic [31:0] exp_epc;
    } vec_t;

    typedef struct {
        int          idx;
        logic        req;
        logic [31:0] rd;
        logic [31:0] epc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic [4:0] rd, input logic we_v, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [31:0] pc, input logic bd,
                                input logic ev, input logic [4:0] ec, input logic [5:0] hw,
                                input logic er, input logic [31:0] bva, input logic req,
                                input logic [31:0] rdv, input logic [31:0] epc);
        vec_t v;
        v.rd = rd; v.we = we_v; v.wa = wa; v.wd = wd; v.pc = pc; v.bd = bd;
        v.ev = ev; v.ec = ec; v.hw = hw; v.er = er; v.bva = bva;
        v.exp_req = req; v.exp_rd = rdv; v.exp_epc = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rd_addr = 5'd0; wr_addr = 5'd0; wr_data = 32'h0; we = 1'b0;
        pc_m = 32'h0; bd_m = 1'b0; exc_code = 5'd0; exc_vld = 1'b0;
        hwint = 6'h0; eret = 1'b0; badvaddr_in = 32'h0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        rd_addr = v.rd; we = v.we; wr_addr = v.wa; wr_data = v.wd; pc_m = v.pc;
        bd_m = v.bd; exc_vld = v.ev; exc_code = v.ec; hwint = v.hw; eret = v.er;
        badvaddr_in = v.bva;
        sb.push_back('{idx: idx, req: v.exp_req, rd: v.exp_rd, epc: v.exp_epc});
        #2;
        if (sb.size() == 0) begin
            check($sformatf("v%0d.scoreboard_empty", idx), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check($sformatf("v%0d.exc_req", e.idx), {31'h0, exc_req}, {31'h0, e.req});
            check($sformatf("v%0d.rd_data", e.idx), rd_data, e.rd);
            check($sformatf("v%0d.epc_out", e.idx), epc_out, e.epc);
        end
    endtask

    initial begin
        logic [31:0] bv1, bv2;
`ifdef CP0_BADVADDR_EN
        bv1 = 32'h0000_1003;
        bv2 = 32'hABCD_0001;
`else
        bv1 = 32'h0;
        bv2 = 32'h0;
`endif
        //            rd  we wa   wd            pc            bd ev ec  hw     er bva           req rd            epc
        vecs.push_back(mk(12, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(15, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'h2019_0007, 32'h0));
        vecs.push_back(mk(12, 1, 12, 32'h401,      32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(12, 0, 0,  32'h0,        32'h3008,     0, 0, 0,  6'h1,  0, 32'h0,        1, 32'h401,      32'h0));
        vecs.push_back(mk(13, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'h400,      32'h3008));
        vecs.push_back(mk(12, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'h403,      32'h3008));
        vecs.push_back(mk(14, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  1, 32'h0,        0, 32'h3008,     32'h3008));
        vecs.push_back(mk(12, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'h401,      32'h3008));
        vecs.push_back(mk(13, 1, 14, 32'hDEADBEEF, 32'h3104,     1, 1, 12, 6'h0,  0, 32'h0,        1, 32'h0,        32'h3008));
        vecs.push_back(mk(13, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'h8000_0030, 32'h3100));
        vecs.push_back(mk(12, 0, 0,  32'h0,        32'h5000,     0, 1, 10, 6'h0,  0, 32'h0,        0, 32'h403,      32'h3100));
        vecs.push_back(mk(14, 1, 14, 32'h2007,     32'h0,        0, 0, 0,  6'h0,  1, 32'h0,        0, 32'h3100,     32'h3100));
        vecs.push_back(mk(14, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'h2004,     32'h2004));
        vecs.push_back(mk(13, 0, 0,  32'h0,        32'h3200,     0, 1, 10, 6'h1,  0, 32'h0,        1, 32'h8000_0030, 32'h2004));
        vecs.push_back(mk(13, 0, 0,  32'h0,        32'h3204,     0, 1, 10, 6'h1,  0, 32'h0,        0, 32'h400,      32'h3200));
        vecs.push_back(mk(12, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h1,  1, 32'h0,        0, 32'h403,      32'h3200));
        vecs.push_back(mk(12, 0, 0,  32'h0,        32'h3300,     0, 0, 0,  6'h1,  0, 32'h0,        1, 32'h401,      32'h3200));
        vecs.push_back(mk(14, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'h3300,     32'h3300));
        vecs.push_back(mk(12, 1, 12, 32'h403,      32'h0,        0, 0, 0,  6'h0,  1, 32'h0,        0, 32'h403,      32'h3300));
        vecs.push_back(mk(12, 1, 13, 32'hFFFFFFFF, 32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'h401,      32'h3300));
        vecs.push_back(mk(13, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'h0,        32'h3300));
        vecs.push_back(mk(3,  0, 0,  32'h0,        32'h3400,     0, 1, 4,  6'h0,  0, 32'h1003,     1, 32'h0,        32'h3300));
        vecs.push_back(mk(8,  0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, bv1,          32'h3400));
        vecs.push_back(mk(13, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  1, 32'h0,        0, 32'h10,       32'h3400));
        vecs.push_back(mk(8,  0, 0,  32'h0,        32'h2,        1, 1, 5,  6'h0,  0, 32'hABCD0001, 1, bv1,          32'h3400));
        vecs.push_back(mk(14, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        vecs.push_back(mk(13, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'h8000_0014, 32'hFFFF_FFFC));
        vecs.push_back(mk(8,  0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, bv2,          32'hFFFF_FFFC));
        vecs.push_back(mk(31, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'h0,        32'hFFFF_FFFC));
        vecs.push_back(mk(12, 1, 12, 32'hFFFF_FFFC, 32'h0,       0, 0, 0,  6'h0,  0, 32'h0,        0, 32'h403,      32'hFFFF_FFFC));
        vecs.push_back(mk(12, 0, 0,  32'h0,        32'h0,        0, 0, 0,  6'h3F, 0, 32'h0,        0, 32'h0000_FC00, 32'hFFFF_FFFC));
        vecs.push_back(mk(14, 1, 14, 32'h3010,     32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        vecs.push_back(mk(14, 1, 12, 32'h403,      32'h0,        0, 0, 0,  6'h0,  0, 32'h0,        0, 32'h3010,     32'h3010));

        idle_inputs();
        reset = 1'b0;
        #1;
        check("reset.exc_req", {31'h0, exc_req}, 32'h0);
        check("reset.sr", rd_data, 32'h0);
        check("handler_pc", handler_pc, 32'h0000_4180);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset asserted mid-handler (EXL=1, EPC=0x3010) must clear state before any edge.
        @(negedge clk);
        idle_inputs();
        hwint = 6'h1;
        rd_addr = 5'd12;
        #1;
        check("pre_abort.sr", rd_data, 32'h403);
        reset = 1'b0;
        #1;
        check("abort.sr", rd_data, 32'h0);
        check("abort.epc_out", epc_out, 32'h0);
        check("abort.exc_req", {31'h0, exc_req}, 32'h0);
        rd_addr = 5'd13;
        #1;
        check("abort.cause", rd_data, 32'h0);
        rd_addr = 5'd14;
        #1;
        check("abort.epc", rd_data, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_reset.exc_req_ie0", {31'h0, exc_req}, 32'h0);

        // Re-enable interrupts after reset; the held line must fire once IE is set.
        @(negedge clk);
        we = 1'b1; wr_addr = 5'd12; wr_data = 32'h401;
        @(negedge clk);
        we = 1'b0; pc_m = 32'h3500;
        #1;
        check("post_reset.exc_req_irq", {31'h0, exc_req}, 32'h1);
        @(negedge clk);
        hwint = 6'h0; rd_addr = 5'd14;
        #1;
        check("post_reset.epc", rd_data, 32'h3500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
